// File: rtl/mod_counter_arbiter_if.sv
// Request/grant bundle between the requesters and mod_counter_arbiter.
// Optional macro CNT_PAUSE_EN adds the pause input.
interface mod_counter_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int CW    = 4
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ*CW-1:0] req_mod;
  logic [N_REQ-1:0]    gnt;
  logic                busy;
  logic [CW-1:0]       count;
  logic                wrap;
  logic [N_REQ-1:0]    done;
  logic                err;
`ifdef CNT_PAUSE_EN
  logic                pause;

  modport master (output req, req_mod, pause,
                  input  gnt, busy, count, wrap, done, err);
  modport slave  (input  req, req_mod, pause,
                  output gnt, busy, count, wrap, done, err);
`else
  modport master (output req, req_mod,
                  input  gnt, busy, count, wrap, done, err);
  modport slave  (input  req, req_mod,
                  output gnt, busy, count, wrap, done, err);
`endif
endinterface

// File: rtl/mod_counter_arbiter.sv
// Round-robin scheduler sharing one modulo counter between N_REQ requesters.
// Optional macro CNT_PAUSE_EN: pause input freezes the counter while in RUN.
module mod_counter_arbiter #(
  parameter int N_REQ = 4,
  parameter int CW    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mod_counter_arbiter_if.slave  bus,
  output logic [1:0]            o_dbg_state
);

  // Handshake: req[i] is a level held until done[i]; a dropped req during RUN
  // cancels the run, gnt is one-hot while RUN, done is a one-cycle pulse.
  localparam int LW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [CW-1:0]    r_count, w_count_nxt;
  logic [CW-1:0]    r_mod_q, w_mod_q_nxt;
  logic [LW-1:0]    r_last, w_last_nxt;
  logic [N_REQ-1:0] r_done, w_done_nxt;
  logic             r_err, w_err_nxt;

  logic [N_REQ-1:0] w_elig;
  logic             w_zero_req;
  logic             w_win_found;
  logic [LW-1:0]    w_win_idx;
  logic [N_REQ-1:0] w_win_onehot;
  logic [CW-1:0]    w_win_mod;
  logic             w_at_end;
  logic             w_owner_req;
  logic             w_wrap;
  logic             w_pause;

`ifdef CNT_PAUSE_EN
  assign w_pause = bus.pause;
`else
  assign w_pause = 1'b0;
`endif

  // Search starts just above the last winner so the previous owner ranks last.
  always_comb begin
    int idx;
    idx          = 0;
    w_elig       = '0;
    w_win_found  = 1'b0;
    w_win_idx    = '0;
    w_win_onehot = '0;
    w_win_mod    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_elig[i] = bus.req[i] && (bus.req_mod[i*CW +: CW] != '0);
    end
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(r_last) + k) % N_REQ;
      if (!w_win_found && w_elig[idx]) begin
        w_win_found       = 1'b1;
        w_win_idx         = LW'(idx);
        w_win_onehot      = '0;
        w_win_onehot[idx] = 1'b1;
        w_win_mod         = bus.req_mod[idx*CW +: CW];
      end
    end
  end

  assign w_zero_req  = |(bus.req & ~w_elig);
  assign w_at_end    = (r_count == (r_mod_q - CW'(1)));
  assign w_owner_req = |(bus.req & r_gnt);

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_count_nxt = r_count;
    w_mod_q_nxt = r_mod_q;
    w_last_nxt  = r_last;
    w_done_nxt  = '0;
    w_err_nxt   = r_err | w_zero_req;
    w_wrap      = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        w_gnt_nxt   = '0;
        w_count_nxt = '0;
        w_state_nxt = ST_IDLE;
        if (w_win_found) begin
          w_state_nxt = ST_RUN;
          w_gnt_nxt   = w_win_onehot;
          w_mod_q_nxt = w_win_mod;
          w_last_nxt  = w_win_idx;
        end
      end
      ST_RUN: begin
        w_wrap = w_at_end && !w_pause;
        // Completion wins over a req drop landing on the final count.
        if (w_wrap) begin
          w_state_nxt = ST_DONE;
          w_count_nxt = '0;
          w_gnt_nxt   = '0;
          w_done_nxt  = r_gnt;
        end else if (!w_owner_req) begin
          w_state_nxt = ST_IDLE;
          w_count_nxt = '0;
          w_gnt_nxt   = '0;
        end else if (!w_pause) begin
          w_count_nxt = r_count + CW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
        w_count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_count <= '0;
      r_mod_q <= '0;
      r_last  <= LW'(N_REQ - 1);
      r_done  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_count <= w_count_nxt;
      r_mod_q <= w_mod_q_nxt;
      r_last  <= w_last_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.busy    = (r_state == ST_RUN);
  assign bus.count   = r_count;
  assign bus.wrap    = w_wrap;
  assign bus.done    = r_done;
  assign bus.err     = r_err;
  assign o_dbg_state = r_state;

endmodule
